// File: rtl/rep7_tx_pkg.sv
// rtl/rep7_tx_pkg.sv - shared defaults and FSM encoding for the repetition-code transmitter
// Purpose: payload width / repetition defaults and state constants used by rep7_tx.
// Ports: none (package).
package rep_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REP    = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/rep7_tx_if.sv
// rtl/rep7_tx_if.sv - payload input and serial chip output bundle for rep7_tx
// Purpose: groups the word handshake and chip stream signals.
// Ports: in_data/in_valid/in_ready word handshake; tx_chip/tx_valid/tx_sof/tx_grp chip stream; done frame-end pulse.
// Modports: master = word source / chip sink, slave = transmitter.
interface rep7_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_chip;
    logic              tx_valid;
    logic              tx_sof;
    logic              tx_grp;
    logic              done;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx_chip, tx_valid, tx_sof, tx_grp, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx_chip, tx_valid, tx_sof, tx_grp, done
    );
endinterface

// File: rtl/rep7_tx_mod_counter.sv
// rtl/rep7_tx_mod_counter.sv - modulo-MOD up counter with enable, clear and wrap flag
// Purpose: counts 0..MOD-1 while enabled; wrap_o marks the enabled cycle at MOD-1.
// Ports: clk, rst (sync active-high), clr_i sync clear, en_i count enable,
//        cnt_o current count, wrap_o high when en_i and count is MOD-1.
module mod_counter #(
    parameter int MOD = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr_i,
    input  logic                                en_i,
    output logic [((MOD > 1) ? $clog2(MOD) : 1)-1:0] cnt_o,
    output logic                                wrap_o
);
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rep7_tx.sv
// rtl/rep7_tx.sv - repetition-code serial transmitter (each payload bit sent REP times, MSB first)
// Purpose: accepts a DATA_W word in IDLE, streams DATA_W*REP chips in SEND, pulses done in GAP.
// Ports: clk; rst (sync active-high); bus (rep7_tx_if.slave): in_* word handshake,
//        tx_chip/tx_valid/tx_sof/tx_grp chip stream, done one-cycle frame-end pulse.
module rep7_tx
    import rep_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REP    = DEF_REP
) (
    input logic       clk,
    input logic       rst,
    rep7_tx_if.slave  bus
);
    localparam int RW = (REP > 1) ? $clog2(REP) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [RW-1:0]     rep_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              rep_wrap;
    logic              bit_wrap;
    logic              in_send;

    assign in_send = (state_q == ST_SEND);

    // Counters sit at zero outside SEND so every frame starts on chip 0 of bit 0.
    mod_counter #(.MOD(REP)) u_rep_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_send),
        .en_i   (in_send),
        .cnt_o  (rep_cnt),
        .wrap_o (rep_wrap)
    );

    mod_counter #(.MOD(DATA_W)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_send),
        .en_i   (rep_wrap),
        .cnt_o  (bit_cnt),
        .wrap_o (bit_wrap)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = bus.in_data;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Current bit always lives in the MSB; shift at the end of each group.
                if (rep_wrap) begin
                    shift_d = shift_q << 1;
                    if (bit_wrap) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    // All outputs decode registered state only.
    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.tx_valid = in_send;
    assign bus.tx_chip  = in_send && shift_q[DATA_W-1];
    assign bus.tx_grp   = in_send && (rep_cnt == '0);
    assign bus.tx_sof   = in_send && (rep_cnt == '0) && (bit_cnt == '0);
    assign bus.done     = (state_q == ST_GAP);
endmodule

// File: doc/rep7_tx.md
REP7_TX -- requirements
Module: rep7_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width per frame.
REQ-002 Parameter REP, default 7, chips transmitted per payload bit (odd, >=3).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  payload word to encode.
REQ-006 in_valid  input  1  in_data valid; transfer on in_valid && in_ready.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 tx_chip  output  1  current serial chip (repeated payload bit).
REQ-009 tx_valid  output  1  tx_chip is meaningful this cycle.
REQ-010 tx_sof  output  1  high on the first chip of a frame only.
REQ-011 tx_grp  output  1  high on the first chip of each REP-chip group.
REQ-012 done  output  1  one-cycle pulse after the last chip of a frame.

Function
REQ-013 FSM states IDLE, SEND, GAP. Reset state IDLE.
REQ-014 IDLE: in_ready=1, tx_valid=0; on in_valid, capture in_data into shift register and go to SEND next cycle.
REQ-015 Latency: first chip appears on tx_chip/tx_valid the cycle after the accepting edge.
REQ-016 SEND: tx_valid=1; tx_chip = current bit, MSB first; each bit held exactly REP consecutive cycles.
REQ-017 Counters: rep_cnt 0..REP-1, bit_cnt 0..DATA_W-1; rep_cnt wraps to 0 and bit_cnt increments at rep_cnt==REP-1.
REQ-018 Frame length in SEND exactly DATA_W*REP cycles (56 at defaults).
REQ-019 tx_grp=1 when rep_cnt==0 in SEND; tx_sof=1 when rep_cnt==0 and bit_cnt==0 in SEND.
REQ-020 At rep_cnt==REP-1 and bit_cnt==DATA_W-1, next state GAP.
REQ-021 GAP: lasts one cycle; tx_valid=0, tx_chip=0, in_ready=0, done=1; then IDLE.
REQ-022 in_ready=0 in SEND and GAP; in_valid there is ignored and in_data not sampled.
REQ-023 Minimum spacing: back-to-back frames separated by GAP plus one IDLE accept cycle (2 cycles tx_valid low).
REQ-024 tx_chip=0 whenever tx_valid=0.
REQ-025 Captured word is stable for the whole frame regardless of later in_data changes.
REQ-026 All outputs registered or decoded from registered state only; no combinational path from in_* to tx_*.

Reset
REQ-027 rst high at an edge forces IDLE, clears counters and shift register.
REQ-028 Outputs after reset: in_ready=1, tx_chip=0, tx_valid=0, tx_sof=0, tx_grp=0, done=0.
REQ-029 Reset mid-frame aborts the frame with no done pulse; tx_valid low from the next cycle.
REQ-030 in_valid asserted during rst is not accepted.

Structure
REQ-031 Shared package rep_pkg holds DATA_W/REP defaults and the FSM state encoding.
REQ-032 One sub-module mod_counter (parameterised modulus, enable, wrap flag) instantiated for rep_cnt and bit_cnt.

Verification
REQ-033 Accept 8'hA5 -> tx_chip = 7x1,7x0,7x1,7x0,7x0,7x1,7x0,7x1 over 56 valid cycles, tx_sof once, tx_grp 8 times, done in cycle 57.
REQ-034 in_valid held high with 8'hFF then 8'h00 -> second frame's first chip starts exactly 2 cycles after first frame's last chip; 56 ones then 56 zeros.
REQ-035 Change in_data and pulse in_valid during SEND -> transmitted chips unchanged, no extra frame.
REQ-036 Assert rst at chip 20 of a frame -> tx_valid=0 next cycle, no done, in_ready=1; next accepted 8'h3C transmits correctly.
REQ-037 Loopback: collect each 7-chip group, flip one chip per group, feed to a 7-input majority voter -> recovered byte equals sent byte for 8'h00, 8'hFF, 8'h5A, 8'hC3.
REQ-038 Non-default REP=3, DATA_W=4, word 4'b1001 -> 12-cycle frame 111 000 000 111.
